// File: rtl/dispatch_unit_pkg.sv
// Shared types for the dispatch stage: the rename/dispatch payload structs, the
// functional-unit encoding and the default core sizes.
package dispatch_unit_pkg;

    localparam int NUM_PREGS_DEFAULT = 128;
    localparam int ROB_DEPTH_DEFAULT = 16;
    localparam int PREG_W            = $clog2(NUM_PREGS_DEFAULT);
    localparam int TAG_W             = $clog2(ROB_DEPTH_DEFAULT);
    localparam int CTRL_W            = 8;

    // Encoding 2'd3 has no name: it is illegal and treated as ALU by routing.
    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_BR  = 2'd1,
        FU_MEM = 2'd2
    } fu_type_t;

    typedef struct packed {
        fu_type_t            fu_type;
        logic [PREG_W-1:0]   pd;
        logic [PREG_W-1:0]   ps1;
        logic [PREG_W-1:0]   ps2;
        logic                has_rd;
        logic                uses_rs1;
        logic                uses_rs2;
        logic [31:0]         pc;
        logic [31:0]         imm;
        logic [CTRL_W-1:0]   ctrl;
    } rename_data;

    typedef struct packed {
        rename_data          instr;
        logic [TAG_W-1:0]    rob_tag;
        logic                ps1_rdy;
        logic                ps2_rdy;
    } dispatch_data;

    typedef struct packed {
        logic alu;
        logic br;
        logic mem;
    } iq_sel_t;

    function automatic iq_sel_t route_fu(input fu_type_t fu);
        iq_sel_t sel;
        sel = '0;
        case (fu)
            FU_BR:   sel.br  = 1'b1;
            FU_MEM:  sel.mem = 1'b1;
            default: sel.alu = 1'b1;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/dispatch_unit_busy.sv
// Physical-register busy table: two combinational read ports, one set port and
// one clear port. Set beats clear on the same preg; preg 0 is never busy.
module busy_table #(
    parameter int NUM_PREGS = 128
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$clog2(NUM_PREGS)-1:0] rd1_idx,
    output logic                         rd1_busy,
    input  logic [$clog2(NUM_PREGS)-1:0] rd2_idx,
    output logic                         rd2_busy,
    input  logic                         set_en,
    input  logic [$clog2(NUM_PREGS)-1:0] set_idx,
    input  logic                         clr_en,
    input  logic [$clog2(NUM_PREGS)-1:0] clr_idx
);

    logic [NUM_PREGS-1:0] busy_q;
    logic [NUM_PREGS-1:0] busy_d;

    // Clear first, then set: a new producer is younger than the writeback.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rd1_busy = busy_q[rd1_idx];
    assign rd2_busy = busy_q[rd2_idx];

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch stage: single-entry dispatch register, ROB allocation, operand
// readiness lookup and issue-queue routing. Optional same-cycle writeback
// bypass into operand readiness is enabled by DISPATCH_WB_BYPASS_EN.
module dispatch_unit
    import dispatch_unit_pkg::*;
#(
    parameter int NUM_PREGS = NUM_PREGS_DEFAULT,
    parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mispredict,
    input  logic                         valid_in,
    input  rename_data                   data_in,
    output logic                         ready_out,
    input  logic                         rob_alloc_ready,
    input  logic [$clog2(ROB_DEPTH)-1:0] rob_tag,
    output logic                         rob_alloc_valid,
    input  logic                         iq_alu_ready,
    input  logic                         iq_br_ready,
    input  logic                         iq_mem_ready,
    output logic                         iq_alu_valid,
    output logic                         iq_br_valid,
    output logic                         iq_mem_valid,
    output dispatch_data                 data_out,
    input  logic                         wb_valid,
    input  logic [$clog2(NUM_PREGS)-1:0] wb_pd
);

    logic       buf_valid_q;
    logic       buf_valid_d;
    rename_data buf_q;
    rename_data buf_d;

    iq_sel_t    sel;
    logic       tgt_ready;
    logic       fire;
    logic       accept;
    logic       ps1_busy;
    logic       ps2_busy;
    logic       wb_hit1;
    logic       wb_hit2;
    logic       ps1_rdy;
    logic       ps2_rdy;

    // Route on the held instruction only, so nothing on data_in reaches an output.
    always_comb begin
        sel       = route_fu(buf_q.fu_type);
        tgt_ready = (sel.alu && iq_alu_ready) ||
                    (sel.br  && iq_br_ready)  ||
                    (sel.mem && iq_mem_ready);
        fire      = buf_valid_q && rob_alloc_ready && tgt_ready && !mispredict;
        ready_out = !mispredict && (!buf_valid_q || fire);
        accept    = valid_in && ready_out;
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        if (mispredict) begin
            buf_valid_d = 1'b0;
        end else if (accept) begin
            buf_valid_d = 1'b1;
            buf_d       = data_in;
        end else if (fire) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
        end
    end

    busy_table #(
        .NUM_PREGS (NUM_PREGS)
    ) u_busy_table (
        .clk      (clk),
        .reset    (reset),
        .rd1_idx  (buf_q.ps1),
        .rd1_busy (ps1_busy),
        .rd2_idx  (buf_q.ps2),
        .rd2_busy (ps2_busy),
        .set_en   (fire && buf_q.has_rd),
        .set_idx  (buf_q.pd),
        .clr_en   (wb_valid),
        .clr_idx  (wb_pd)
    );

`ifdef DISPATCH_WB_BYPASS_EN
    assign wb_hit1 = wb_valid && (wb_pd == buf_q.ps1);
    assign wb_hit2 = wb_valid && (wb_pd == buf_q.ps2);
`else
    assign wb_hit1 = 1'b0;
    assign wb_hit2 = 1'b0;
`endif

    assign ps1_rdy = !buf_q.uses_rs1 || !ps1_busy || wb_hit1;
    assign ps2_rdy = !buf_q.uses_rs2 || !ps2_busy || wb_hit2;

    // An empty register presents all zeros so squashed contents never leak out.
    always_comb begin
        data_out = '0;
        if (buf_valid_q) begin
            data_out.instr   = buf_q;
            data_out.rob_tag = rob_tag;
            data_out.ps1_rdy = ps1_rdy;
            data_out.ps2_rdy = ps2_rdy;
        end
    end

    assign rob_alloc_valid = fire;
    assign iq_alu_valid    = fire && sel.alu;
    assign iq_br_valid     = fire && sel.br;
    assign iq_mem_valid    = fire && sel.mem;

    illegal_fu_type_a: assert property (@(posedge clk) disable iff (reset)
        !(buf_valid_q && (buf_q.fu_type == 2'd3)));

    iq_strobe_onehot_a: assert property (@(posedge clk) disable iff (reset)
        $onehot0({iq_alu_valid, iq_br_valid, iq_mem_valid}) &&
        (rob_alloc_valid == (iq_alu_valid || iq_br_valid || iq_mem_valid)));

    stall_holds_buf_a: assert property (@(posedge clk) disable iff (reset)
        (buf_valid_q && !fire && !mispredict) |=> (buf_valid_q && $stable(buf_q)));

endmodule

// File: tb/tb_dispatch_unit.sv
// Scoreboard bench for dispatch_unit: directed instructions push their
// hand-computed dispatch results; a negedge monitor pops and compares them.
module tb_dispatch_unit;
   import dispatch_unit_pkg::*;

   typedef struct {
      fu_type_t          fu;
      logic [TAG_W-1:0]  tag;
      logic [PREG_W-1:0] pd;
      logic [31:0]       pc;
      logic              rdy1;
      logic              rdy2;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              mispredict;
   logic              valid_in;
   rename_data        data_in;
   logic              ready_out;
   logic              rob_alloc_ready;
   logic [TAG_W-1:0]  rob_tag;
   logic              rob_alloc_valid;
   logic              iq_alu_ready;
   logic              iq_br_ready;
   logic              iq_mem_ready;
   logic              iq_alu_valid;
   logic              iq_br_valid;
   logic              iq_mem_valid;
   dispatch_data      data_out;
   logic              wb_valid;
   logic [PREG_W-1:0] wb_pd;

   exp_t sbQueue[$];
   int   testsRun = 0;
   int   failCount = 0;
   logic fireSeen = 1'b0;

`ifdef DISPATCH_WB_BYPASS_EN
   localparam logic BYPASS_RDY = 1'b1;
`else
   localparam logic BYPASS_RDY = 1'b0;
`endif

   dispatch_unit dut (
      .clk             (clk),
      .reset           (reset),
      .mispredict      (mispredict),
      .valid_in        (valid_in),
      .data_in         (data_in),
      .ready_out       (ready_out),
      .rob_alloc_ready (rob_alloc_ready),
      .rob_tag         (rob_tag),
      .rob_alloc_valid (rob_alloc_valid),
      .iq_alu_ready    (iq_alu_ready),
      .iq_br_ready     (iq_br_ready),
      .iq_mem_ready    (iq_mem_ready),
      .iq_alu_valid    (iq_alu_valid),
      .iq_br_valid     (iq_br_valid),
      .iq_mem_valid    (iq_mem_valid),
      .data_out        (data_out),
      .wb_valid        (wb_valid),
      .wb_pd           (wb_pd)
   );

   always #5 clk = ~clk;

   // Minimal ROB model: hands out the next tag after every allocation it sees.
   always @(posedge clk) begin
      if (fireSeen) begin
         rob_tag <= rob_tag + 1'b1;
      end
      fireSeen = 1'b0;
   end

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic rename_data mkInstr(input fu_type_t fu, input int pd, input int ps1, input int ps2,
                                          input logic hasRd, input logic u1, input logic u2, input logic [31:0] pc);
      rename_data d;
      d.fu_type  = fu;
      d.pd       = PREG_W'(pd);
      d.ps1      = PREG_W'(ps1);
      d.ps2      = PREG_W'(ps2);
      d.has_rd   = hasRd;
      d.uses_rs1 = u1;
      d.uses_rs2 = u2;
      d.pc       = pc;
      d.imm      = pc + 32'h40;
      d.ctrl     = CTRL_W'(pd);
      return d;
   endfunction

   function automatic exp_t mkExp(input fu_type_t fu, input int tag, input int pd, input logic [31:0] pc,
                                  input logic r1, input logic r2);
      exp_t e;
      e.fu   = fu;
      e.tag  = TAG_W'(tag);
      e.pd   = PREG_W'(pd);
      e.pc   = pc;
      e.rdy1 = r1;
      e.rdy2 = r2;
      return e;
   endfunction

   function automatic logic [2:0] expSel(input fu_type_t fu);
      case (fu)
         FU_BR:   return 3'b010;
         FU_MEM:  return 3'b100;
         default: return 3'b001;
      endcase
   endfunction

   // Offer one instruction to the DUT and return just after the edge that accepts it.
   task automatic applyStimulus(input rename_data d, input bit expectFire, input exp_t e);
      int waited;
      valid_in = 1'b1;
      data_in  = d;
      if (expectFire) begin
         sbQueue.push_back(e);
      end
      waited = 0;
      @(negedge clk);
      while (!ready_out && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!ready_out) begin
         testsRun++;
         failCount++;
         $display("[TB] FAIL accept_timeout: got ready_out=0 for pc %0h, expected 1", d.pc);
         if (expectFire) begin
            void'(sbQueue.pop_back());
         end
         valid_in = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      valid_in = 1'b0;
   endtask

   task automatic pulseWb(input int pd);
      wb_valid = 1'b1;
      wb_pd    = PREG_W'(pd);
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
   endtask

   // Monitor: every dispatch strobe must match the oldest expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && (rob_alloc_valid || iq_alu_valid || iq_br_valid || iq_mem_valid)) begin
         fireSeen = 1'b1;
         if (sbQueue.size() == 0) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL unexpected_dispatch: got dispatch of pc %0h, expected none", data_out.instr.pc);
         end else begin
            e = sbQueue.pop_front();
            checkOutput("rob_alloc_valid", 128'(rob_alloc_valid), 128'(1'b1));
            checkOutput("iq_select", 128'({iq_mem_valid, iq_br_valid, iq_alu_valid}), 128'(expSel(e.fu)));
            checkOutput("rob_tag", 128'(data_out.rob_tag), 128'(e.tag));
            checkOutput("pd", 128'(data_out.instr.pd), 128'(e.pd));
            checkOutput("pc", 128'(data_out.instr.pc), 128'(e.pc));
            checkOutput("ps1_rdy", 128'(data_out.ps1_rdy), 128'(e.rdy1));
            checkOutput("ps2_rdy", 128'(data_out.ps2_rdy), 128'(e.rdy2));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish by 200000, expected earlier finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rename_data   instrD;
      dispatch_data expHeld;

      reset           = 1'b1;
      mispredict      = 1'b0;
      valid_in        = 1'b0;
      data_in         = '0;
      rob_alloc_ready = 1'b1;
      rob_tag         = '0;
      iq_alu_ready    = 1'b1;
      iq_br_ready     = 1'b1;
      iq_mem_ready    = 1'b1;
      wb_valid        = 1'b0;
      wb_pd           = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      @(negedge clk);
      checkOutput("reset_ready_out", 128'(ready_out), 128'(1'b1));
      checkOutput("reset_rob_alloc_valid", 128'(rob_alloc_valid), 128'(1'b0));
      checkOutput("reset_iq_valid", 128'({iq_mem_valid, iq_br_valid, iq_alu_valid}), 128'(3'b000));
      checkOutput("reset_data_out", 128'(data_out), 128'(0));
      @(posedge clk);
      #1;

      // A writes p5; B reads p5 back-to-back and sees it busy.
      applyStimulus(mkInstr(FU_ALU, 5, 3, 4, 1, 1, 1, 32'h100), 1, mkExp(FU_ALU, 0, 5, 32'h100, 1, 1));
      applyStimulus(mkInstr(FU_ALU, 6, 5, 0, 1, 1, 0, 32'h104), 1, mkExp(FU_ALU, 1, 6, 32'h104, 0, 1));
      @(posedge clk);
      #1;
      pulseWb(5);
      applyStimulus(mkInstr(FU_BR, 0, 5, 6, 0, 1, 1, 32'h108), 1, mkExp(FU_BR, 2, 0, 32'h108, 1, 0));
      @(posedge clk);
      #1;

      // Load held by a full memory queue for three cycles.
      iq_mem_ready = 1'b0;
      instrD = mkInstr(FU_MEM, 8, 0, 0, 1, 1, 0, 32'h10c);
      applyStimulus(instrD, 1, mkExp(FU_MEM, 3, 8, 32'h10c, 1, 1));
      expHeld.instr   = instrD;
      expHeld.rob_tag = TAG_W'(3);
      expHeld.ps1_rdy = 1'b1;
      expHeld.ps2_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("stall_ready_out", 128'(ready_out), 128'(1'b0));
         checkOutput("stall_iq_mem_valid", 128'(iq_mem_valid), 128'(1'b0));
         checkOutput("stall_data_out", 128'(data_out), 128'(expHeld));
         @(posedge clk);
         #1;
      end
      iq_mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Branch stalled on the ROB, then squashed while the ROB frees up.
      rob_alloc_ready = 1'b0;
      applyStimulus(mkInstr(FU_BR, 0, 1, 2, 0, 1, 1, 32'h110), 0, mkExp(FU_BR, 0, 0, 32'h110, 1, 1));
      @(negedge clk);
      checkOutput("rob_stall_alloc", 128'(rob_alloc_valid), 128'(1'b0));
      checkOutput("rob_stall_ready_out", 128'(ready_out), 128'(1'b0));
      @(posedge clk);
      #1;
      mispredict      = 1'b1;
      rob_alloc_ready = 1'b1;
      @(negedge clk);
      checkOutput("mispredict_ready_out", 128'(ready_out), 128'(1'b0));
      @(posedge clk);
      #1;
      mispredict = 1'b0;
      @(negedge clk);
      checkOutput("post_flush_ready_out", 128'(ready_out), 128'(1'b1));
      checkOutput("post_flush_data_out", 128'(data_out), 128'(0));
      @(posedge clk);
      #1;

      // Fire setting p7 in the same cycle as a writeback of p7: set wins.
      applyStimulus(mkInstr(FU_ALU, 7, 1, 2, 1, 1, 1, 32'h114), 1, mkExp(FU_ALU, 4, 7, 32'h114, 1, 1));
      pulseWb(7);
      applyStimulus(mkInstr(FU_ALU, 10, 7, 0, 1, 1, 1, 32'h118), 1, mkExp(FU_ALU, 5, 10, 32'h118, 0, 1));

      // Writeback of ps2 on the reader's fire cycle: only the bypass build sees it.
      applyStimulus(mkInstr(FU_ALU, 9, 0, 0, 1, 0, 0, 32'h11c), 1, mkExp(FU_ALU, 6, 9, 32'h11c, 1, 1));
      applyStimulus(mkInstr(FU_MEM, 11, 0, 9, 1, 0, 1, 32'h120), 1, mkExp(FU_MEM, 7, 11, 32'h120, 1, BYPASS_RDY));
      pulseWb(9);
      @(posedge clk);
      #1;

      // Reset in the middle of a ROB stall drops the held instruction and busy bits.
      rob_alloc_ready = 1'b0;
      applyStimulus(mkInstr(FU_ALU, 12, 0, 0, 1, 0, 0, 32'h124), 0, mkExp(FU_ALU, 0, 12, 32'h124, 1, 1));
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midreset_data_out", 128'(data_out), 128'(0));
      checkOutput("midreset_ready_out", 128'(ready_out), 128'(1'b1));
      @(posedge clk);
      #1;
      reset           = 1'b0;
      rob_alloc_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      applyStimulus(mkInstr(FU_BR, 0, 6, 7, 0, 1, 1, 32'h128), 1, mkExp(FU_BR, 8, 0, 32'h128, 1, 1));

      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("scoreboard_drained", 128'(sbQueue.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/dispatch_unit.md
# dispatch_unit

- Dispatch stage of the out-of-order core, sitting between `rename` and the ROB and issue queues.
- Accepts one renamed instruction per cycle over a valid/ready handshake and holds it in a single-entry dispatch register.
- In a single transaction it allocates a ROB tag, looks up source-operand readiness in an internal physical-register busy table, and routes the instruction to the ALU, branch or LSU issue queue.
- Stalls rename when the ROB or the target queue is full, and flushes on `mispredict`.

## Interface
Parameters:
- NUM_PREGS, 128, number of physical registers; busy-table depth.
- ROB_DEPTH, 16, ROB entries; tag width is $clog2(ROB_DEPTH).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- mispredict  in  1  flush; squashes the dispatch register.
- valid_in  in  1  rename has a valid instruction on data_in.
- data_in  in  rename_data  renamed instruction: fu_type, pd, ps1, ps2, has_rd, uses_rs1, uses_rs2, pc, imm, ctrl fields.
- ready_out  out  1  dispatch can accept data_in this cycle.
- rob_alloc_ready  in  1  ROB has a free entry.
- rob_tag  in  ROB tag width  tag the ROB will assign on allocation.
- rob_alloc_valid  out  1  allocation request; equals the dispatch fire signal.
- iq_alu_ready / iq_br_ready / iq_mem_ready  in  1 each  queue has space.
- iq_alu_valid / iq_br_valid / iq_mem_valid  out  1 each  write strobe, one-hot or zero.
- data_out  out  dispatch_data  rename_data plus rob_tag, ps1_rdy and ps2_rdy.
- wb_valid  in  1  writeback or squash-release broadcast.
- wb_pd  in  $clog2(NUM_PREGS)  physical register becoming ready.

## Operation
- Accept: `accept = valid_in && ready_out`. On accept, data_in is latched into the dispatch register `buf` and `buf_valid` is set.
- Target readiness: `tgt_ready` is the ready of the queue selected by `buf.fu_type` (0 = ALU, 1 = BR, 2 = MEM). fu_type 3 is illegal; it routes to ALU and fires an assertion.
- Fire: `fire = buf_valid && rob_alloc_ready && tgt_ready && !mispredict`.
  - On fire, exactly one iq_*_valid is driven, together with rob_alloc_valid.
  - data_out.rob_tag = rob_tag.
- `ready_out = !mispredict && (!buf_valid || fire)`. Accept and fire in the same cycle are legal and keep the register full.
- Busy table: one bit per physical register.
  - psN_rdy = !busy[psN] || !uses_rsN.
  - On fire with has_rd, set busy[pd].
  - On wb_valid, clear busy[wb_pd].
  - Preg 0 is never busy; writes to it are ignored.
- Simultaneous set and clear of the same preg: the set wins, because the new producer is younger.
- Mispredict:
  - Clears buf_valid and suppresses fire and accept that cycle.
  - Leaves the busy table untouched. The ROB's squash walk releases squashed destinations over wb_valid/wb_pd.
- Back-pressure: all outputs hold stable while buf_valid is set and fire is low.

## Timing
- Reset values:
  - buf_valid = 0; all busy bits = 0.
  - ready_out = 1 (once reset deasserts and mispredict is low).
  - rob_alloc_valid = 0; iq_*_valid = 0.
  - data_out = 0.
- Latency: an instruction accepted at edge N can fire in cycle N+1. Sustained throughput is 1 instruction per cycle.
- Outputs are combinational from buf, the busy table and the ready inputs. There are no combinational paths from valid_in or data_in to any output.
- A wb_valid asserted in cycle N is visible in the busy table from cycle N+1.
- Reset asserted mid-stall drops the held instruction; there is no replay.

## Configuration
- DISPATCH_WB_BYPASS_EN defined:
  - psN_rdy additionally ORs in (wb_valid && wb_pd == psN) in the same cycle.
  - This closes the one-cycle window in which a writeback is missed.
- Undefined:
  - No bypass. The issue queues must snoop wb_valid/wb_pd on the write cycle.
  - Operands are reported not-ready during that window.

## Structure
- Shared package holds:
  - rename_data and dispatch_data structs.
  - fu_type_t enum (FU_ALU, FU_BR, FU_MEM).
  - NUM_PREGS and ROB_DEPTH defaults.
- One sub-module, `busy_table`:
  - Parameterised by NUM_PREGS.
  - Two combinational read ports, one set port, one clear port.
  - Set-wins priority; preg 0 hard-wired not busy.
- Top-level `dispatch_unit` holds the dispatch register, the fire/route logic and the bypass.

## Test plan
- Reset then ALU instruction with pd=5, ps1=3, ps2=4 and all targets ready -> one cycle later iq_alu_valid=1, rob_alloc_valid=1, ps1_rdy=ps2_rdy=1, busy[5]=1.
- Back-to-back instructions where instruction B reads p5 written by instruction A -> B dispatches with ps1_rdy=0. Then wb_pd=5 -> a following reader gets ps1_rdy=1.
- iq_mem_ready=0 with a load in buf for 3 cycles -> ready_out=0, outputs stable. iq_mem_ready=1 -> iq_mem_valid pulses once.
- mispredict while buf holds a branch and rob_alloc_ready=0 -> no fire, buf_valid=0 next cycle, ready_out=1.
- Same-cycle fire setting p7 and wb_pd=7 -> busy[7]=1 afterward.
- With DISPATCH_WB_BYPASS_EN defined: wb_pd equals ps2 on the fire cycle -> ps2_rdy=1. Without the macro -> ps2_rdy=0.
